// File: rtl/axis_width_downsizer.sv
// ---------------------------------------------------------------------------
// axis_width_downsizer
//
// Splits each wide AXI4-Stream word into RATIO narrower beats, least
// significant slice first. A word is held in a register and presented one
// slice per output handshake. A new word can be accepted on the same cycle
// the last slice is consumed, so a continuous input stream produces a
// continuous output stream.
//
// Optional feature macro: OUT_COUNTER_EN
//   When defined, adds a 32-bit output-beat counter (out_count) with a
//   synchronous clear input (out_count_reset).
//
// Ports:
//   axis_aclk        clock, rising edge
//   axis_aresetn     synchronous active-low reset
//   s00_axis_tvalid  input word valid
//   s00_axis_tready  ready for an input word
//   s00_axis_tdata   input word [IN_WIDTH]
//   m00_axis_tvalid  output slice valid
//   m00_axis_tready  downstream ready
//   m00_axis_tdata   output slice [OUT_WIDTH]
//   m00_axis_tlast   high on the final slice of each word
//   busy             high while a word is held
//   out_count        output-beat counter (OUT_COUNTER_EN only)
//   out_count_reset  synchronous clear of out_count (OUT_COUNTER_EN only)
// ---------------------------------------------------------------------------
module axis_width_downsizer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 axis_aclk,
  input  logic                 axis_aresetn,
  input  logic                 s00_axis_tvalid,
  output logic                 s00_axis_tready,
  input  logic [IN_WIDTH-1:0]  s00_axis_tdata,
  output logic                 m00_axis_tvalid,
  input  logic                 m00_axis_tready,
  output logic [OUT_WIDTH-1:0] m00_axis_tdata,
  output logic                 m00_axis_tlast,
  output logic                 busy
`ifdef OUT_COUNTER_EN
  ,
  output logic [31:0]          out_count,
  input  logic                 out_count_reset
`endif
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                state_r, state_n;
  logic [IN_WIDTH-1:0]   word_r, word_n;
  logic [IDX_W-1:0]      idx_r, idx_n;
  logic                  full_r;
  logic                  at_last;
  logic                  in_hs;
  logic                  out_hs;
  logic [OUT_WIDTH-1:0]  slices [RATIO];

  assign full_r  = (state_r == HOLD);
  assign at_last = (idx_r == LAST_IDX);

  // Ready is the only combinational path: a held word frees its slot on the
  // cycle its last slice leaves, which is what allows back-to-back words.
  assign s00_axis_tready = !full_r | (at_last & m00_axis_tready);

  assign in_hs  = s00_axis_tvalid & s00_axis_tready;
  assign out_hs = full_r & m00_axis_tready;

  for (genvar g = 0; g < RATIO; g++) begin : g_slice
    assign slices[g] = word_r[g*OUT_WIDTH +: OUT_WIDTH];
  end

  assign m00_axis_tvalid = full_r;
  assign m00_axis_tdata  = slices[idx_r];
  assign m00_axis_tlast  = full_r & at_last;
  assign busy            = full_r;

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state_r <= EMPTY;
      word_r  <= '0;
      idx_r   <= '0;
    end else begin
      state_r <= state_n;
      word_r  <= word_n;
      idx_r   <= idx_n;
    end
  end

  // Next-state logic. The input word is only captured on an input handshake,
  // so s00_axis_tdata is ignored at all other times.
  always_comb begin
    state_n = state_r;
    word_n  = word_r;
    idx_n   = idx_r;
    case (state_r)
      EMPTY: begin
        if (in_hs) begin
          word_n  = s00_axis_tdata;
          idx_n   = '0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (out_hs) begin
          if (!at_last) begin
            idx_n = idx_r + 1'b1;
          end else if (in_hs) begin
            word_n = s00_axis_tdata;
            idx_n  = '0;
          end else begin
            idx_n   = '0;
            state_n = EMPTY;
          end
        end
      end
      default: begin
        state_n = EMPTY;
        idx_n   = '0;
      end
    endcase
  end

`ifdef OUT_COUNTER_EN
  // Clear takes priority over a coincident output handshake.
  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn || out_count_reset) begin
      out_count <= '0;
    end else if (out_hs) begin
      out_count <= out_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_width_downsizer.sv
// ---------------------------------------------------------------------------
// tb_axis_width_downsizer
//
// Scoreboard bench for axis_width_downsizer (32 -> 8). Stimulus pushes the
// expected slices of each accepted word into exp_q; a monitor running on the
// falling clock edge pops and compares every output handshake.
// ---------------------------------------------------------------------------
module tb_axis_width_downsizer;

  logic        clk;
  logic        axis_aresetn;
  logic        s00_axis_tvalid;
  logic        s00_axis_tready;
  logic [31:0] s00_axis_tdata;
  logic        m00_axis_tvalid;
  logic        m00_axis_tready;
  logic [7:0]  m00_axis_tdata;
  logic        m00_axis_tlast;
  logic        busy;
`ifdef OUT_COUNTER_EN
  logic [31:0] out_count;
  logic        out_count_reset;
`endif

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;

  // expected beats: {tlast, tdata}
  logic [8:0] exp_q[$];

  bit streaming = 0;
  int stream_beats = 0;
  int stream_first = 0;
  int stream_last = 0;
  int hs_cycle = 0;

  axis_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
    .axis_aclk       (clk),
    .axis_aresetn    (axis_aresetn),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tready (s00_axis_tready),
    .s00_axis_tdata  (s00_axis_tdata),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tready (m00_axis_tready),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tlast  (m00_axis_tlast),
    .busy            (busy)
`ifdef OUT_COUNTER_EN
    ,
    .out_count       (out_count),
    .out_count_reset (out_count_reset)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: compare every output handshake against the scoreboard.
  always @(negedge clk) begin
    if (axis_aresetn && m00_axis_tvalid && m00_axis_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat actual=0x%0h required=none", m00_axis_tdata);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        checkOutput("beat_data", {24'h0, m00_axis_tdata}, {24'h0, e[7:0]});
        checkOutput("beat_last", {31'h0, m00_axis_tlast}, {31'h0, e[8]});
        checkOutput("beat_busy", {31'h0, busy}, 32'h1);
      end
      if (streaming) begin
        if (stream_beats == 0) stream_first = cycle_cnt;
        stream_last = cycle_cnt;
        stream_beats++;
      end
    end
  end

  // Offer one word; push its four slices when the handshake is seen.
  task automatic applyStimulus(input logic [31:0] word, input bit keep_valid,
                               output int waits);
    bit done;
    done = 0;
    waits = 0;
    s00_axis_tvalid = 1'b1;
    s00_axis_tdata  = word;
    while (!done && waits < 20) begin
      @(negedge clk);
      if (s00_axis_tready) begin
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), word[k*8 +: 8]});
        hs_cycle = cycle_cnt;
        done = 1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL input_handshake_timeout actual=no_ready required=ready word=0x%0h", word);
    end
    if (!keep_valid) s00_axis_tvalid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, exp_q.size(), 0);
  endtask

  task automatic applyReset();
    axis_aresetn    = 1'b0;
    s00_axis_tvalid = 1'b0;
    m00_axis_tready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    axis_aresetn = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    int w;
    int wsum;
    int h0;
    s00_axis_tdata  = '0;
`ifdef OUT_COUNTER_EN
    out_count_reset = 1'b0;
`endif
    applyReset();

    // Reset state
    @(negedge clk);
    checkOutput("rst_tvalid", {31'h0, m00_axis_tvalid}, 32'h0);
    checkOutput("rst_tlast",  {31'h0, m00_axis_tlast}, 32'h0);
    checkOutput("rst_busy",   {31'h0, busy}, 32'h0);
    checkOutput("rst_tdata",  {24'h0, m00_axis_tdata}, 32'h0);
    checkOutput("rst_s_tready", {31'h0, s00_axis_tready}, 32'h1);
    @(posedge clk);
    #1;

    // Single word: beats 04,00,10,E1 starting one cycle after the handshake
    m00_axis_tready = 1'b1;
    applyStimulus(32'hE1100004, 0, w);
    @(negedge clk);
    checkOutput("single_latency_tvalid", {31'h0, m00_axis_tvalid}, 32'h1);
    checkOutput("single_first_tdata", {24'h0, m00_axis_tdata}, 32'h04);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("single_end_tvalid", {31'h0, m00_axis_tvalid}, 32'h0);
    checkOutput("single_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Streaming: 15 words back to back
    applyReset();
    m00_axis_tready = 1'b1;
    stream_beats = 0;
    streaming = 1;
    wsum = 0;
    h0 = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(32'hE1100000 + i, 1, w);
      if (i == 0) h0 = hs_cycle;
      else wsum += w;
    end
    s00_axis_tvalid = 1'b0;
    checkOutput("stream_input_spacing", hs_cycle - h0, 56);
    checkOutput("stream_ready_waits", wsum, 42);
    waitDrain("stream_drained");
    streaming = 0;
    checkOutput("stream_beats", stream_beats, 60);
    checkOutput("stream_no_bubble", stream_last - stream_first, 59);

`ifdef OUT_COUNTER_EN
    @(negedge clk);
    checkOutput("count_after_stream", out_count, 60);
    @(posedge clk);
    #1;
    applyStimulus(32'h01020304, 0, w);
    out_count_reset = 1'b1;
    @(posedge clk);
    #1;
    out_count_reset = 1'b0;
    @(negedge clk);
    checkOutput("count_clear_wins", out_count, 0);
    waitDrain("count_drained");
    @(negedge clk);
    checkOutput("count_after_clear", out_count, 3);
    @(posedge clk);
    #1;
`endif

    // Backpressure on slice 1 of 0xAABBCCDD
    m00_axis_tready = 1'b1;
    applyStimulus(32'hAABBCCDD, 0, w);
    @(posedge clk);
    #1;
    m00_axis_tready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("stall_tdata", {24'h0, m00_axis_tdata}, 32'hCC);
      checkOutput("stall_tvalid", {31'h0, m00_axis_tvalid}, 32'h1);
      checkOutput("stall_s_tready", {31'h0, s00_axis_tready}, 32'h0);
      @(posedge clk);
      #1;
    end
    m00_axis_tready = 1'b1;
    waitDrain("stall_drained");

    // Ready drop on the last slice with a new word waiting
    applyStimulus(32'h11223344, 0, w);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    m00_axis_tready = 1'b0;
    s00_axis_tvalid = 1'b1;
    s00_axis_tdata  = 32'h55667788;
    @(negedge clk);
    checkOutput("lastdrop_tlast", {31'h0, m00_axis_tlast}, 32'h1);
    checkOutput("lastdrop_tdata", {24'h0, m00_axis_tdata}, 32'h11);
    checkOutput("lastdrop_s_tready", {31'h0, s00_axis_tready}, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("lastdrop_hold_tdata", {24'h0, m00_axis_tdata}, 32'h11);
    @(posedge clk);
    #1;
    m00_axis_tready = 1'b1;
    applyStimulus(32'h55667788, 0, w);
    checkOutput("lastdrop_same_cycle_load", w, 0);
    waitDrain("lastdrop_drained");

    // Reset after two of four slices
    applyStimulus(32'hDEADBEEF, 0, w);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    m00_axis_tready = 1'b0;
    axis_aresetn = 1'b0;
    @(posedge clk);
    #1;
    axis_aresetn = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checkOutput("midrst_tvalid", {31'h0, m00_axis_tvalid}, 32'h0);
    checkOutput("midrst_busy", {31'h0, busy}, 32'h0);
    checkOutput("midrst_s_tready", {31'h0, s00_axis_tready}, 32'h1);
    checkOutput("midrst_tdata", {24'h0, m00_axis_tdata}, 32'h0);
    @(posedge clk);
    #1;
    m00_axis_tready = 1'b1;
    applyStimulus(32'h0A0B0C0D, 0, w);
    @(negedge clk);
    checkOutput("midrst_next_first", {24'h0, m00_axis_tdata}, 32'h0D);
    waitDrain("midrst_drained");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
